env_gen_mc: RTL and testbench
=============================

ENV_GEN_MC -- requirements
Module: env_gen_mc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, meaning the number of time-multiplexed envelope channels (2..64).
REQ-002 SHALL have parameter MANT_W, default 13, meaning the rate mantissa width.
REQ-003 SHALL have parameter EXP_W, default 4, meaning the rate shift-exponent width.
REQ-004 SHALL have parameter ACC_W, default 19, meaning the envelope level and rate operand width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd_ready  output  1  command accepted this cycle.
REQ-010 cmd_voice  input  clog2(NUM_VOICES)  target voice.
REQ-011 cmd_op  input  1  0 = KEY_ON, 1 = KEY_OFF.
REQ-012 cmd_mant  input  MANT_W  rate mantissa.
REQ-013 cmd_exp  input  EXP_W  rate shift exponent.
REQ-014 cmd_target  input  ACC_W  attack target level; ignored for KEY_OFF.
REQ-015 out_valid  output  1  output sample strobe.
REQ-016 out_voice  output  clog2(NUM_VOICES)  voice of current output.
REQ-017 out_level  output  ACC_W  envelope level of out_voice.
REQ-018 out_active  output  1  out_voice state is not IDLE.

Function
REQ-019 Slot counter SHALL advance by 1 every cycle from 0 to NUM_VOICES-1 and wrap to 0.
REQ-020 Per-voice state SHALL be IDLE, ATTACK, HOLD or RELEASE, plus stored level (ACC_W), rate operand (ACC_W) and target (ACC_W).
REQ-021 Rate operand SHALL be {1'b1, mant} zero-extended to ACC_W and shifted left by exp; bits above ACC_W-1 discarded.
REQ-022 cmd_ready SHALL be high combinationally only when cmd_valid is high and slot equals cmd_voice; a transfer occurs when both are high.
REQ-023 An unaccepted command SHALL be held stable by the source; worst-case wait is NUM_VOICES-1 cycles.
REQ-024 On KEY_ON transfer: state := ATTACK, rate and target latched, level unchanged (legato from current level).
REQ-025 On KEY_OFF transfer: state := RELEASE, rate latched; if voice is IDLE it SHALL stay IDLE with level 0.
REQ-026 In a cycle with a transfer, the slot's level SHALL NOT be updated; rate application starts at its next visit.
REQ-027 ATTACK visit: if level + rate >= target (full ACC_W+1-bit compare), level := target and state := HOLD; else level += rate.
REQ-028 KEY_ON with target <= current level SHALL reach HOLD on the first visit with level := target.
REQ-029 RELEASE visit: if level <= rate, level := 0 and state := IDLE; else level -= rate.
REQ-030 IDLE and HOLD visits SHALL leave level unchanged.
REQ-031 Outputs SHALL be registered: one cycle after slot s is processed, out_valid=1, out_voice=s, out_level and out_active reflect its post-update state.
REQ-032 Level SHALL never wrap: no overflow above target, no underflow below 0.

Reset
REQ-033 While rst_n low: slot=0, all voices IDLE, level/rate/target 0, out_valid=0, out_voice=0, out_level=0, out_active=0; cmd_ready SHALL be 0.
REQ-034 First out_valid SHALL occur one cycle after the first clock edge with rst_n high, reporting voice 0.
REQ-035 Reset asserted mid-attack or mid-release SHALL abort immediately; no command is retained.

Verification (NUM_VOICES=4, defaults otherwise)
REQ-036 KEY_ON v1, mant=0, exp=0 (rate 8192), target=0x10000 -> v1 level 8192, 16384, ... 65536 on 8 successive visits (4 cycles apart), then HOLD, out_active=1.
REQ-037 KEY_OFF v1 from 65536, mant=0, exp=1 (rate 16384) -> 49152, 32768, 16384, 0, IDLE, out_active=0 on the 4th visit.
REQ-038 mant=0x1FFF, exp=15 -> operand truncated to 0x78000; KEY_ON target 0x7FFFF from 0 -> level 0x78000, then 0x7FFFF HOLD.
REQ-039 cmd_valid for v3 raised when slot=0 -> cmd_ready low 3 cycles, high in slot-3 cycle; v3 level unchanged that cycle.
REQ-040 KEY_OFF to IDLE v2 -> accepted, v2 stays IDLE, level 0; KEY_ON with target below current level -> HOLD at target on first visit.
REQ-041 rst_n low during v0 attack -> all outputs 0 immediately; after release, voices IDLE, out_voice sequence 0,1,2,3,0.

Source files
------------

// File: rtl/env_gen_mc.sv
// Time-multiplexed envelope generator: one voice is visited per clock and its
// attack/hold/release level is stepped by a per-voice shifted-mantissa rate.
module env_gen_mc #(
  parameter int NUM_VOICES = 16,
  parameter int MANT_W     = 13,
  parameter int EXP_W      = 4,
  parameter int ACC_W      = 19
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cmd_voice,
  input  logic                          cmd_op,
  input  logic [MANT_W-1:0]             cmd_mant,
  input  logic [EXP_W-1:0]              cmd_exp,
  input  logic [ACC_W-1:0]              cmd_target,
  output logic                          out_valid,
  output logic [$clog2(NUM_VOICES)-1:0] out_voice,
  output logic [ACC_W-1:0]              out_level,
  output logic                          out_active
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST_SLOT = VW'(NUM_VOICES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [VW-1:0]    slot_q, slot_d;
  logic [1:0]       state_q  [NUM_VOICES];
  logic [1:0]       state_d  [NUM_VOICES];
  logic [ACC_W-1:0] level_q  [NUM_VOICES];
  logic [ACC_W-1:0] level_d  [NUM_VOICES];
  logic [ACC_W-1:0] rate_q   [NUM_VOICES];
  logic [ACC_W-1:0] rate_d   [NUM_VOICES];
  logic [ACC_W-1:0] target_q [NUM_VOICES];
  logic [ACC_W-1:0] target_d [NUM_VOICES];

  logic                out_valid_q, out_valid_d;
  logic [VW-1:0]       out_voice_q, out_voice_d;
  logic [ACC_W-1:0]    out_level_q, out_level_d;
  logic                out_active_q, out_active_d;

  logic [1:0]       cur_state;
  logic [ACC_W-1:0] cur_level, cur_rate, cur_target;
  logic [1:0]       upd_state;
  logic [ACC_W-1:0] upd_level, upd_rate, upd_target;
  logic [ACC_W:0]   attack_sum;
  logic [ACC_W-1:0] cmd_base, cmd_rate;
  logic             xfer;

  // Ready is gated by rst_n so nothing can be accepted while held in reset.
  assign cmd_ready = rst_n & cmd_valid & (slot_q == cmd_voice);
  assign xfer      = cmd_ready;

  assign cmd_base = ACC_W'({1'b1, cmd_mant});
  assign cmd_rate = cmd_base << cmd_exp;

  assign cur_state  = state_q[slot_q];
  assign cur_level  = level_q[slot_q];
  assign cur_rate   = rate_q[slot_q];
  assign cur_target = target_q[slot_q];

  // One extra bit so a large rate near full scale cannot wrap past the target.
  assign attack_sum = {1'b0, cur_level} + {1'b0, cur_rate};

  always_comb begin
    upd_state  = cur_state;
    upd_level  = cur_level;
    upd_rate   = cur_rate;
    upd_target = cur_target;
    if (xfer) begin
      upd_rate = cmd_rate;
      if (!cmd_op) begin
        upd_state  = ST_ATTACK;
        upd_target = cmd_target;
      end else if (cur_state == ST_IDLE) begin
        upd_level = '0;
      end else begin
        upd_state = ST_RELEASE;
      end
    end else begin
      case (cur_state)
        ST_ATTACK: begin
          if (attack_sum >= {1'b0, cur_target}) begin
            upd_level = cur_target;
            upd_state = ST_HOLD;
          end else begin
            upd_level = attack_sum[ACC_W-1:0];
          end
        end
        ST_RELEASE: begin
          if (cur_level <= cur_rate) begin
            upd_level = '0;
            upd_state = ST_IDLE;
          end else begin
            upd_level = cur_level - cur_rate;
          end
        end
        default: begin
          upd_level = cur_level;
        end
      endcase
    end
  end

  always_comb begin
    slot_d       = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    out_valid_d  = 1'b1;
    out_voice_d  = slot_q;
    out_level_d  = upd_level;
    out_active_d = (upd_state != ST_IDLE);
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic sel;
      assign sel = (slot_q == VW'(gi));

      always_comb begin
        state_d[gi]  = sel ? upd_state  : state_q[gi];
        level_d[gi]  = sel ? upd_level  : level_q[gi];
        rate_d[gi]   = sel ? upd_rate   : rate_q[gi];
        target_d[gi] = sel ? upd_target : target_q[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q[gi]  <= ST_IDLE;
          level_q[gi]  <= '0;
          rate_q[gi]   <= '0;
          target_q[gi] <= '0;
        end else begin
          state_q[gi]  <= state_d[gi];
          level_q[gi]  <= level_d[gi];
          rate_q[gi]   <= rate_d[gi];
          target_q[gi] <= target_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      out_level_q  <= '0;
      out_active_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      out_valid_q  <= out_valid_d;
      out_voice_q  <= out_voice_d;
      out_level_q  <= out_level_d;
      out_active_q <= out_active_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_voice  = out_voice_q;
  assign out_level  = out_level_q;
  assign out_active = out_active_q;

endmodule

// File: tb/tb_env_gen_mc.sv
// Directed bench for env_gen_mc with four voices: command table plus
// hand-written handshake-wait and mid-envelope reset sequences.
module tb_env_gen_mc;
  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_voice = '0;
  logic        cmd_op = 1'b0;
  logic [12:0] cmd_mant = '0;
  logic [3:0]  cmd_exp = '0;
  logic [18:0] cmd_target = '0;
  logic        out_valid;
  logic [1:0]  out_voice;
  logic [18:0] out_level;
  logic        out_active;

  int checks = 0;
  int errors = 0;

  env_gen_mc #(.NUM_VOICES(NV)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_voice(cmd_voice),
    .cmd_op(cmd_op), .cmd_mant(cmd_mant), .cmd_exp(cmd_exp), .cmd_target(cmd_target),
    .out_valid(out_valid), .out_voice(out_voice), .out_level(out_level),
    .out_active(out_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       voice;
    logic             op;
    logic [12:0]      mant;
    logic [3:0]       ex;
    logic [18:0]      target;
    logic [18:0]      lvl0;
    logic             act0;
    int               nvis;
    logic [9:0][18:0] lvl;
    logic             act_final;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Drive a command at a falling edge and hold it until accepted.
  task automatic send_cmd(input logic [1:0] v, input logic op, input logic [12:0] m,
                          input logic [3:0] e, input logic [18:0] t);
    int waits = 0;
    @(negedge clk);
    cmd_voice = v; cmd_op = op; cmd_mant = m; cmd_exp = e; cmd_target = t;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && waits < 8) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_visit(input logic [1:0] v);
    int n = 0;
    @(negedge clk);
    while (out_voice !== v && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("visit_voice", 32'(out_voice), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: state carries over from one vector to the next.
    vecs[0] = '{voice:2'd1, op:1'b0, mant:13'd0, ex:4'd0, target:19'h10000,
                lvl0:19'd0, act0:1'b1, nvis:9, lvl:'0, act_final:1'b1};
    for (int i = 0; i < 8; i++) vecs[0].lvl[i] = 19'((i + 1) * 8192);
    vecs[0].lvl[8] = 19'h10000;
    vecs[1] = '{voice:2'd1, op:1'b1, mant:13'd0, ex:4'd1, target:19'd0,
                lvl0:19'h10000, act0:1'b1, nvis:4, lvl:'0, act_final:1'b0};
    vecs[1].lvl[0] = 19'd49152; vecs[1].lvl[1] = 19'd32768;
    vecs[1].lvl[2] = 19'd16384; vecs[1].lvl[3] = 19'd0;
    vecs[2] = '{voice:2'd2, op:1'b0, mant:13'h1FFF, ex:4'd15, target:19'h7FFFF,
                lvl0:19'd0, act0:1'b1, nvis:3, lvl:'0, act_final:1'b1};
    vecs[2].lvl[0] = 19'h78000; vecs[2].lvl[1] = 19'h7FFFF; vecs[2].lvl[2] = 19'h7FFFF;
    vecs[3] = '{voice:2'd2, op:1'b0, mant:13'd0, ex:4'd0, target:19'h00100,
                lvl0:19'h7FFFF, act0:1'b1, nvis:2, lvl:'0, act_final:1'b1};
    vecs[3].lvl[0] = 19'h00100; vecs[3].lvl[1] = 19'h00100;
    vecs[4] = '{voice:2'd3, op:1'b1, mant:13'd0, ex:4'd0, target:19'd0,
                lvl0:19'd0, act0:1'b0, nvis:1, lvl:'0, act_final:1'b0};
    vecs[5] = '{voice:2'd2, op:1'b1, mant:13'd0, ex:4'd0, target:19'd0,
                lvl0:19'h00100, act0:1'b1, nvis:1, lvl:'0, act_final:1'b0};
    vecs[6] = '{voice:2'd0, op:1'b0, mant:13'd0, ex:4'd0, target:19'h01000,
                lvl0:19'd0, act0:1'b1, nvis:2, lvl:'0, act_final:1'b1};
    vecs[6].lvl[0] = 19'h01000; vecs[6].lvl[1] = 19'h01000;

    // Reset state, with a request that would otherwise match slot 0.
    cmd_valid = 1'b1; cmd_voice = 2'd0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_voice", 32'(out_voice), 32'd0);
    check("rst_level", 32'(out_level), 32'd0);
    check("rst_active", 32'(out_active), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("start_valid", 32'(out_valid), 32'd1);
      check("start_voice", 32'(out_voice), 32'(i % NV));
    end

    for (int k = 0; k < 7; k++) begin
      send_cmd(vecs[k].voice, vecs[k].op, vecs[k].mant, vecs[k].ex, vecs[k].target);
      $display("cmd %0d voice=%0d op=%0d mant=%0h exp=%0d target=%0h level=%0h active=%0d",
               k, vecs[k].voice, vecs[k].op, vecs[k].mant, vecs[k].ex, vecs[k].target,
               out_level, out_active);
      check("xfer_voice", 32'(out_voice), 32'(vecs[k].voice));
      check("xfer_level", 32'(out_level), 32'(vecs[k].lvl0));
      check("xfer_active", 32'(out_active), 32'(vecs[k].act0));
      for (int i = 0; i < vecs[k].nvis; i++) begin
        wait_visit(vecs[k].voice);
        check("visit_level", 32'(out_level), 32'(vecs[k].lvl[i]));
        check("visit_active", 32'(out_active),
              32'((i == vecs[k].nvis - 1) ? vecs[k].act_final : 1'b1));
      end
    end

    // Request for voice 3 raised while slot 0 is current: ready only in slot 3.
    begin
      int n = 0;
      @(negedge clk);
      while (out_voice !== 2'd3 && n < 8) begin
        @(negedge clk);
        n++;
      end
      check("align_voice", 32'(out_voice), 32'd3);
    end
    cmd_voice = 2'd3; cmd_op = 1'b0; cmd_mant = '0; cmd_exp = '0; cmd_target = 19'h40;
    cmd_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("wait_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    check("wait_ready_high", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    $display("cmd wait voice=3 level=%0h active=%0d", out_level, out_active);
    check("wait_xfer_voice", 32'(out_voice), 32'd3);
    check("wait_xfer_level", 32'(out_level), 32'd0);
    check("wait_xfer_active", 32'(out_active), 32'd1);
    wait_visit(2'd3);
    check("wait_hold_level", 32'(out_level), 32'h40);
    #1;
    check("idle_ready", 32'(cmd_ready), 32'd0);

    // Mid-attack reset on voice 0 (legato from 0x1000).
    send_cmd(2'd0, 1'b0, 13'd0, 4'd0, 19'h7FFFF);
    $display("cmd abort voice=0 level=%0h active=%0d", out_level, out_active);
    check("abort_xfer_level", 32'(out_level), 32'h01000);
    wait_visit(2'd0);
    check("abort_attack_level", 32'(out_level), 32'h03000);
    check("abort_attack_active", 32'(out_active), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_voice = 2'd0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_voice", 32'(out_voice), 32'd0);
    check("abort_level", 32'(out_level), 32'd0);
    check("abort_active", 32'(out_active), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_voice", 32'(out_voice), 32'(i % NV));
      check("post_level", 32'(out_level), 32'd0);
      check("post_active", 32'(out_active), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
